// File: rtl/serial_divisibility_check_encoder_if.sv
// serial_divisibility_check_encoder_if: parallel-in / serial-out handshake bundle
interface serial_divisibility_check_encoder_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic out_bit;
  logic out_first;
  logic out_last;
  modport master (
    output in_valid, in_data, out_ready,
    input in_ready, out_valid, out_bit, out_first, out_last
  );
  modport slave (
    input in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bit, out_first, out_last
  );
endinterface

// File: rtl/serial_divisibility_check_encoder.sv
// serial_divisibility_check_encoder: shifts a word out MSB-first, then appends check bits making the frame divisible by DIVISOR
module serial_divisibility_check_encoder #(
  parameter int WIDTH = 8,
  parameter int DIVISOR = 5
) (
  input logic clk,
  input logic rst,
  serial_divisibility_check_encoder_if.slave bus
);
  localparam int CB = $clog2(DIVISOR);
  localparam int CW = $clog2(WIDTH + CB + 1);
  localparam logic [CB:0] DIV = (CB+1)'(DIVISOR);
  localparam logic [CW-1:0] W_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CB - 1);
  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;
  state_t state;
  logic [WIDTH-1:0] sh;
  logic [CB-1:0] ck, rem, rem_n, m, c;
  logic [CB:0] t0, t;
  logic [CW-1:0] cnt;
  logic bit_now, fire;
  assign bit_now = state == DATA ? sh[WIDTH-1] : state == CHECK ? ck[CB-1] : 1'b0;
  assign fire = bus.out_ready && state != IDLE;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state != IDLE;
  assign bus.out_bit = bit_now;
  assign bus.out_first = state == DATA && cnt == '0;
  assign bus.out_last = state == CHECK && cnt == C_LAST;
  // rem_n includes the bit being handed off; c is the CB-bit suffix that zeroes the final remainder
  always_comb begin
    t0 = {rem, bit_now};
    rem_n = t0 >= DIV ? CB'(t0 - DIV) : CB'(t0);
    m = rem_n;
    t = '0;
    for (int i = 0; i < CB; i++) begin
      t = {m, 1'b0};
      m = t >= DIV ? CB'(t - DIV) : CB'(t);
    end
    c = m == '0 ? '0 : CB'(DIV - {1'b0, m});
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      ck <= '0;
      rem <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sh <= bus.in_data;
          rem <= '0;
          cnt <= '0;
          state <= DATA;
        end
        DATA: if (fire) begin
          rem <= rem_n;
          sh <= sh << 1;
          cnt <= cnt == W_LAST ? '0 : cnt + 1'b1;
          if (cnt == W_LAST) begin
            ck <= c;
            state <= CHECK;
          end
        end
        CHECK: if (fire) begin
          rem <= rem_n;
          ck <= ck << 1;
          cnt <= cnt == C_LAST ? '0 : cnt + 1'b1;
          if (cnt == C_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
